// File: rtl/cmd_feeder_pkg.sv
// Shared types for the command feeder: FSM state encoding and the packed
// command record that travels through the FIFO.
package cmd_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACT = 3'd2,
        RUN      = 3'd3,
        DONE     = 3'd4
    } state_e;

    // Command record: operand x in the high bits, mode on in the low bits.
    localparam int CMD_W = 10;

    function automatic logic [CMD_W-1:0] pack_cmd(input logic [7:0] cx,
                                                  input logic [1:0] con);
        return {cx, con};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Single-clock synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int CMD_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] din,
    output logic [CMD_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A push while full is dropped, so a stored entry is never overwritten.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_feeder.sv
// Command feeder: queues host commands, issues them one at a time to main
// with a start pulse, then tracks main's active flag through completion.
module cmd_feeder
    import cmd_feeder_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_x,
    input  logic [1:0]       cmd_on,
    output logic [7:0]       x,
    output logic [1:0]       on,
    output logic             start,
    input  logic             active,
    input  logic [1:0]       regime,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_regime,
    output logic             err,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e           state_q;
    logic [TW-1:0]    tmo_cnt_q;
    logic [7:0]       x_q;
    logic [1:0]       on_q;
    logic             start_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       done_regime_q;
    logic [CNT_W-1:0] done_cnt_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_din;
    logic [CMD_W-1:0] fifo_dout;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_din  = pack_cmd(cmd_x, cmd_on);
    // The head stays queued while in flight and is released on leaving DONE.
    assign fifo_pop  = (state_q == DONE);

    cmd_fifo #(
        .DEPTH (DEPTH),
        .CMD_W (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tmo_cnt_q     <= '0;
            x_q           <= '0;
            on_q          <= '0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            done_regime_q <= '0;
            done_cnt_q    <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= ISSUE;
                        x_q     <= fifo_dout[CMD_W-1:2];
                        on_q    <= fifo_dout[1:0];
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q   <= WAIT_ACT;
                    tmo_cnt_q <= '0;
                end
                WAIT_ACT: begin
                    // active wins over an expiring timeout in the same cycle.
                    if (active) begin
                        state_q <= RUN;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_q <= DONE;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!active) begin
                        state_q       <= DONE;
                        done_q        <= 1'b1;
                        done_regime_q <= regime;
                        done_cnt_q    <= done_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    x_q     <= '0;
                    on_q    <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    x_q     <= '0;
                    on_q    <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x           = x_q;
    assign on          = on_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign done_regime = done_regime_q;
    assign done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_cmd_feeder.sv
// Directed bench for cmd_feeder: a small model of main drives active after
// each start pulse, and each scenario task checks cycle-exact outputs.
module tb_cmd_feeder;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_x;
    logic [1:0]       cmd_on;
    logic [7:0]       x;
    logic [1:0]       on;
    logic             start;
    logic             active;
    logic [1:0]       regime;
    logic             busy;
    logic             done;
    logic [1:0]       done_regime;
    logic             err;
    logic [CNT_W-1:0] done_cnt;

    int n_vec;
    int n_err;

    // Main model knobs: active rises act_delay cycles after start for act_len
    // cycles (0 = never rises); act_hold keeps it high until cleared.
    int act_delay;
    int act_len;
    bit act_hold;

    logic [9:0] issued_q[$];
    logic [9:0] exp_q[$];
    int done_seen;
    int err_seen;
    int both_seen;

    cmd_feeder #(
        .DEPTH   (4),
        .TIMEOUT (8),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_on      (cmd_on),
        .x           (x),
        .on          (on),
        .start       (start),
        .active      (active),
        .regime      (regime),
        .busy        (busy),
        .done        (done),
        .done_regime (done_regime),
        .err         (err),
        .done_cnt    (done_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1);
    end

    initial begin
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (start && act_len > 0) begin
                repeat (act_delay) @(negedge clk);
                active = 1'b1;
                repeat (act_len) @(negedge clk);
                while (act_hold) @(negedge clk);
                active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (start) issued_q.push_back({x, on});
            if (done) done_seen++;
            if (err) err_seen++;
            if (done && err) both_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] px, input logic [1:0] pon, output bit acc);
        cmd_valid = 1'b1;
        cmd_x     = px;
        cmd_on    = pon;
        acc       = cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int quiet;
        quiet = 0;
        ok    = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        act_len = 0;
        repeat (2) tick();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_vec++; if (x !== 8'h00) begin n_err++; $display("FAIL reset_x: got %h want 00", x); end
        n_vec++; if (on !== 2'b00) begin n_err++; $display("FAIL reset_on: got %b want 00", on); end
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", start); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (done_regime !== 2'b00) begin n_err++; $display("FAIL reset_done_regime: got %b want 00", done_regime); end
        n_vec++; if (done_cnt !== 8'd0) begin n_err++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit acc;
        int base_d;
        act_delay = 2;
        act_len   = 3;
        act_hold  = 1'b0;
        regime    = 2'b10;
        base_d    = done_seen;
        push(8'h5A, 2'b01, acc);
        n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL basic_accept: got %b want 1", acc); end
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL basic_idle_start: got %b want 0", start); end
        tick();
        n_vec++; if (start !== 1'b1) begin n_err++; $display("FAIL basic_start: got %b want 1", start); end
        n_vec++; if ({x, on} !== {8'h5A, 2'b01}) begin n_err++; $display("FAIL basic_issue_cmd: got %h/%b want 5a/01", x, on); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL basic_start_k%0d: got %b want 0", k, start); end
            n_vec++; if (done !== (k == 6)) begin n_err++; $display("FAIL basic_done_k%0d: got %b want %b", k, done, (k == 6)); end
            if (k <= 6) begin
                n_vec++; if ({x, on} !== {8'h5A, 2'b01}) begin n_err++; $display("FAIL basic_hold_k%0d: got %h/%b want 5a/01", k, x, on); end
            end
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_end_busy: got %b want 0", busy); end
        n_vec++; if (x !== 8'h00) begin n_err++; $display("FAIL basic_end_x: got %h want 00", x); end
        n_vec++; if (done_regime !== 2'b10) begin n_err++; $display("FAIL basic_done_regime: got %b want 10", done_regime); end
        n_vec++; if (done_cnt !== 8'd1) begin n_err++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        n_vec++; if (done_seen - base_d !== 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", done_seen - base_d); end
    endtask

    task automatic test_timeout();
        bit acc;
        bit ok;
        int base_e;
        int base_i;
        logic [CNT_W-1:0] c0;
        act_len = 0;
        base_e  = err_seen;
        base_i  = issued_q.size();
        c0      = done_cnt;
        push(8'hA5, 2'b10, acc);
        push(8'h3C, 2'b11, acc);
        n_vec++; if ({start, x, on} !== {1'b1, 8'hA5, 2'b10}) begin n_err++; $display("FAIL tmo_issue: got %b %h/%b want 1 a5/10", start, x, on); end
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 9) begin
                act_delay = 1;
                act_len   = 2;
            end
            n_vec++; if (err !== (k == 9)) begin n_err++; $display("FAIL tmo_err_k%0d: got %b want %b", k, err, (k == 9)); end
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL tmo_done_k%0d: got %b want 0", k, done); end
        end
        n_vec++; if (done_cnt !== c0) begin n_err++; $display("FAIL tmo_cnt_held: got %0d want %0d", done_cnt, c0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_idle_busy: got %b want 0", busy); end
        wait_idle(100, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL tmo_wait_idle1: got %b want 1", ok); end
        n_vec++; if (issued_q.size() - base_i !== 2) begin n_err++; $display("FAIL tmo_issue_count: got %0d want 2", issued_q.size() - base_i); end
        else if (issued_q[base_i + 1] !== {8'h3C, 2'b11}) begin n_err++; $display("FAIL tmo_second_cmd: got %h want %h", issued_q[base_i + 1], {8'h3C, 2'b11}); end
        n_vec++; if (done_cnt !== CNT_W'(c0 + 1)) begin n_err++; $display("FAIL tmo_cnt_after: got %0d want %0d", done_cnt, c0 + 1); end
        // active first seen in the final WAIT_ACT cycle still counts as success.
        act_delay = 8;
        act_len   = 1;
        push(8'h11, 2'b00, acc);
        wait_idle(100, ok);
        n_vec++; if (done_cnt !== CNT_W'(c0 + 2)) begin n_err++; $display("FAIL tmo_edge_success_cnt: got %0d want %0d", done_cnt, c0 + 2); end
        n_vec++; if (err_seen - base_e !== 1) begin n_err++; $display("FAIL tmo_edge_success_err: got %0d want 1", err_seen - base_e); end
        act_delay = 9;
        push(8'h22, 2'b01, acc);
        wait_idle(100, ok);
        n_vec++; if (done_cnt !== CNT_W'(c0 + 2)) begin n_err++; $display("FAIL tmo_late_cnt: got %0d want %0d", done_cnt, c0 + 2); end
        n_vec++; if (err_seen - base_e !== 2) begin n_err++; $display("FAIL tmo_late_err: got %0d want 2", err_seen - base_e); end
    endtask

    task automatic test_stall();
        bit acc;
        bit ok;
        int base_i;
        int base_d;
        logic [7:0] px;
        logic [1:0] pon;
        act_delay = 1;
        act_len   = 1;
        act_hold  = 1'b1;
        base_i    = issued_q.size();
        base_d    = done_seen;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            px  = 8'h80 + 8'(i * 3);
            pon = 2'(i);
            push(px, pon, acc);
            if (acc) exp_q.push_back({px, pon});
            n_vec++; if (acc !== (i < 4)) begin n_err++; $display("FAIL stall_accept_%0d: got %b want %b", i, acc, (i < 4)); end
        end
        repeat (5) tick();
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b want 0", cmd_ready); end
        act_hold = 1'b0;
        wait_idle(300, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL stall_wait_idle: got %b want 1", ok); end
        n_vec++; if (issued_q.size() - base_i !== exp_q.size()) begin n_err++; $display("FAIL stall_issue_count: got %0d want %0d", issued_q.size() - base_i, exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++; if (issued_q[base_i + i] !== exp_q[i]) begin n_err++; $display("FAIL stall_order_%0d: got %h want %h", i, issued_q[base_i + i], exp_q[i]); end
            end
        end
        n_vec++; if (done_seen - base_d !== 4) begin n_err++; $display("FAIL stall_done_count: got %0d want 4", done_seen - base_d); end
    endtask

    task automatic test_full_pop();
        bit acc;
        bit ok;
        bit found;
        int base_i;
        act_delay = 1;
        act_len   = 1;
        act_hold  = 1'b1;
        base_i    = issued_q.size();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            push(8'h40 + 8'(i), 2'(3 - i), acc);
            exp_q.push_back({8'h40 + 8'(i), 2'(3 - i)});
        end
        repeat (3) tick();
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL fp_full: got %b want 0", cmd_ready); end
        act_hold = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL fp_done_seen: got %b want 1", found); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL fp_ready_in_done: got %b want 0", cmd_ready); end
        push(8'hEE, 2'b10, acc);
        n_vec++; if (acc !== 1'b0) begin n_err++; $display("FAIL fp_push_rejected: got %b want 0", acc); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL fp_ready_after_pop: got %b want 1", cmd_ready); end
        push(8'h4F, 2'b01, acc);
        exp_q.push_back({8'h4F, 2'b01});
        n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL fp_next_push: got %b want 1", acc); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL fp_full_again: got %b want 0", cmd_ready); end
        wait_idle(300, ok);
        n_vec++; if (issued_q.size() - base_i !== exp_q.size()) begin n_err++; $display("FAIL fp_issue_count: got %0d want %0d", issued_q.size() - base_i, exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++; if (issued_q[base_i + i] !== exp_q[i]) begin n_err++; $display("FAIL fp_order_%0d: got %h want %h", i, issued_q[base_i + i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        bit ok;
        int base_i;
        act_delay = 1;
        act_len   = 1;
        act_hold  = 1'b1;
        push(8'h91, 2'b01, acc);
        push(8'h92, 2'b10, acc);
        push(8'h93, 2'b11, acc);
        repeat (2) tick();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_in_flight: got %b want 1", busy); end
        rst = 1'b1;
        tick();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rm_cmd_ready: got %b want 1", cmd_ready); end
        n_vec++; if ({busy, start, done, err} !== 4'b0000) begin n_err++; $display("FAIL rm_flags: got %b want 0000", {busy, start, done, err}); end
        n_vec++; if ({x, on} !== 10'h000) begin n_err++; $display("FAIL rm_cmd_out: got %h want 000", {x, on}); end
        n_vec++; if (done_cnt !== 8'd0) begin n_err++; $display("FAIL rm_done_cnt: got %0d want 0", done_cnt); end
        n_vec++; if (done_regime !== 2'b00) begin n_err++; $display("FAIL rm_done_regime: got %b want 00", done_regime); end
        rst = 1'b0;
        act_hold = 1'b0;
        base_i = issued_q.size();
        repeat (12) tick();
        n_vec++; if (issued_q.size() - base_i !== 0) begin n_err++; $display("FAIL rm_no_start: got %0d starts want 0", issued_q.size() - base_i); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_stays_idle: got %b want 0", busy); end
        push(8'h77, 2'b11, acc);
        tick();
        n_vec++; if ({start, x, on} !== {1'b1, 8'h77, 2'b11}) begin n_err++; $display("FAIL rm_new_issue: got %b %h/%b want 1 77/11", start, x, on); end
        wait_idle(100, ok);
        n_vec++; if (done_cnt !== 8'd1) begin n_err++; $display("FAIL rm_new_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        bit acc;
        bit ok;
        int sent;
        int base_d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        act_delay = 1;
        act_len   = 1;
        act_hold  = 1'b0;
        base_d    = done_seen;
        sent      = 0;
        for (int g = 0; g < 4000 && sent < 255; g++) begin
            cmd_valid = 1'b1;
            cmd_x     = g[7:0];
            cmd_on    = g[1:0];
            acc       = cmd_ready;
            tick();
            if (acc) sent++;
        end
        cmd_valid = 1'b0;
        n_vec++; if (sent !== 255) begin n_err++; $display("FAIL wrap_sent: got %0d want 255", sent); end
        wait_idle(200, ok);
        n_vec++; if (done_cnt !== 8'd255) begin n_err++; $display("FAIL wrap_pre: got %0d want 255", done_cnt); end
        push(8'hFF, 2'b00, acc);
        wait_idle(100, ok);
        n_vec++; if (done_cnt !== 8'd0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", done_cnt); end
        n_vec++; if (done_seen - base_d !== 256) begin n_err++; $display("FAIL wrap_done_pulses: got %0d want 256", done_seen - base_d); end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        done_seen = 0;
        err_seen  = 0;
        both_seen = 0;
        act_delay = 1;
        act_len   = 0;
        act_hold  = 1'b0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_on    = '0;
        regime    = 2'b00;
        test_reset();
        test_basic();
        test_timeout();
        test_stall();
        test_full_pop();
        test_reset_mid();
        test_wrap();
        n_vec++; if (both_seen !== 0) begin n_err++; $display("FAIL done_err_together: got %0d cycles want 0", both_seen); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
